// File: rtl/muldiv_unit_pkg.sv
// Shared op-code and FSM encodings for the multiply/divide unit.
package muldiv_unit_pkg;

   typedef enum logic [2:0] {
      MD_MULT  = 3'd0,
      MD_MULTU = 3'd1,
      MD_DIV   = 3'd2,
      MD_DIVU  = 3'd3,
      MD_MTHI  = 3'd4,
      MD_MTLO  = 3'd5
   } md_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2
   } md_state_e;

   // MULT, MULTU, DIV and DIVU occupy codes 0..3
   function automatic logic is_iter_op(input logic [2:0] op);
      return (op[2] == 1'b0);
   endfunction

   function automatic logic is_div_op(input logic [2:0] op);
      return (op[2:1] == 2'b01);
   endfunction

   function automatic logic is_signed_op(input logic [2:0] op);
      return (op == MD_MULT) || (op == MD_DIV);
   endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Unsigned WIDTH-cycle shift datapath: shift-add multiply or restoring divide.
// After the last step {acc_o, sr_o} holds the product, or acc_o=remainder, sr_o=quotient.
module muldiv_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic             div_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             last_o,
   output logic [WIDTH-1:0] acc_o,
   output logic [WIDTH-1:0] sr_o
);

   localparam int CW = $clog2(WIDTH);

   logic [WIDTH-1:0] acc_q, acc_d, sr_q, sr_d, opnd_q;
   logic             div_q, run_q, fits;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH:0]   shifted;
   logic [WIDTH+1:0] lhs, rhs, sum;
   logic             cin;

   // One adder serves both modes; divide uses it as a trial subtraction
   always_comb begin
      shifted = {acc_q, sr_q[WIDTH-1]};
      if (div_q) begin
         lhs = {1'b0, shifted};
         rhs = ~{2'b00, opnd_q};
         cin = 1'b1;
      end else begin
         lhs = {2'b00, acc_q};
         rhs = sr_q[0] ? {2'b00, opnd_q} : '0;
         cin = 1'b0;
      end
      sum  = lhs + rhs + {{(WIDTH+1){1'b0}}, cin};
      fits = ~sum[WIDTH+1];
      if (div_q) begin
         acc_d = fits ? sum[WIDTH-1:0] : shifted[WIDTH-1:0];
         sr_d  = {sr_q[WIDTH-2:0], fits};
      end else begin
         acc_d = sum[WIDTH:1];
         sr_d  = {sum[0], sr_q[WIDTH-1:1]};
      end
   end

   assign last_o = run_q && (cnt_q == CW'(WIDTH-1));
   assign acc_o  = acc_q;
   assign sr_o   = sr_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q  <= '0;
         sr_q   <= '0;
         opnd_q <= '0;
         div_q  <= 1'b0;
         run_q  <= 1'b0;
         cnt_q  <= '0;
      end else if (load_i) begin
         acc_q  <= '0;
         sr_q   <= a_i;
         opnd_q <= b_i;
         div_q  <= div_i;
         run_q  <= 1'b1;
         cnt_q  <= '0;
      end else if (run_q) begin
         acc_q <= acc_d;
         sr_q  <= sr_d;
         cnt_q <= cnt_q + CW'(1);
         if (last_o)
            run_q <= 1'b0;
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// MIPS HI/LO multiply/divide unit: operand sign handling, special cases and
// the architectural HI/LO registers around the shared iterative datapath.
module muldiv_unit
   import muldiv_unit_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   md_state_e          state_q;
   logic [2:0]         op_q;
   logic               sign_a_q, sign_b_q, b_zero_q;
   logic               busy_q, done_q, dbz_q;
   logic [WIDTH-1:0]   a_q, a_mag_q, b_mag_q, hi_q, lo_q;

   logic               sign_a_d, sign_b_d;
   logic [WIDTH-1:0]   a_mag_d, b_mag_d;
   logic               iter_load, iter_last;
   logic [WIDTH-1:0]   iter_acc, iter_sr;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   quo, rem, fix_hi_d, fix_lo_d;

   always_comb begin
      sign_a_d = is_signed_op(op) & a[WIDTH-1];
      sign_b_d = is_signed_op(op) & b[WIDTH-1];
      a_mag_d  = sign_a_d ? -a : a;
      b_mag_d  = sign_b_d ? -b : b;
   end

   // The first CALC cycle (busy still low) loads the datapath from latched magnitudes
   assign iter_load = (state_q == ST_CALC) && !busy_q;

   muldiv_iter #(.WIDTH(WIDTH)) u_iter (
      .clk    (clk),
      .rst    (rst),
      .load_i (iter_load),
      .div_i  (is_div_op(op_q)),
      .a_i    (a_mag_q),
      .b_i    (b_mag_q),
      .last_o (iter_last),
      .acc_o  (iter_acc),
      .sr_o   (iter_sr)
   );

   // Remainder takes the dividend's sign; quotient truncates toward zero
   always_comb begin
      prod = {iter_acc, iter_sr};
      quo  = iter_sr;
      rem  = iter_acc;
      if (sign_a_q ^ sign_b_q) begin
         prod = -prod;
         quo  = -quo;
      end
      if (sign_a_q)
         rem = -rem;
      if (!is_div_op(op_q)) begin
         fix_hi_d = prod[2*WIDTH-1:WIDTH];
         fix_lo_d = prod[WIDTH-1:0];
      end else if (b_zero_q) begin
         fix_hi_d = a_q;
         fix_lo_d = '1;
      end else begin
         fix_hi_d = rem;
         fix_lo_d = quo;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         op_q     <= '0;
         sign_a_q <= 1'b0;
         sign_b_q <= 1'b0;
         b_zero_q <= 1'b0;
         a_q      <= '0;
         a_mag_q  <= '0;
         b_mag_q  <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         dbz_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         dbz_q  <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (start) begin
                  if (is_iter_op(op)) begin
                     op_q     <= op;
                     sign_a_q <= sign_a_d;
                     sign_b_q <= sign_b_d;
                     b_zero_q <= (b == '0);
                     a_q      <= a;
                     a_mag_q  <= a_mag_d;
                     b_mag_q  <= b_mag_d;
                     state_q  <= ST_CALC;
                  end else if (op == MD_MTHI) begin
                     hi_q <= a;
                  end else if (op == MD_MTLO) begin
                     lo_q <= a;
                  end
               end
            end
            ST_CALC: begin
               busy_q <= 1'b1;
               if (iter_last)
                  state_q <= ST_FIX;
            end
            ST_FIX: begin
               hi_q    <= fix_hi_d;
               lo_q    <= fix_lo_d;
               done_q  <= 1'b1;
               dbz_q   <= is_div_op(op_q) & b_zero_q;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign div_by_zero = dbz_q;
   assign hi          = hi_q;
   assign lo          = lo_q;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Multi-cycle multiply/divide unit for the MIPS150 datapath. It owns the architectural HI/LO registers and services MULT/MULTU/DIV/DIVU/MTHI/MTLO issued by the execute stage. It exposes HI/LO continuously so the ALU's MFHI/MFLO path can read them. It asserts busy so the pipeline stalls any HI/LO consumer until the result has been written.

Parameters:
WIDTH, 32, operand width; HI/LO are each WIDTH bits and the product is 2*WIDTH bits.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request strobe; sampled only when busy=0
op  input  3  operation code, encodings in shared header
a  input  WIDTH  rs operand (dividend / multiplicand / MTHI-MTLO source)
b  input  WIDTH  rt operand (divisor / multiplier)
busy  output  1  iterative operation in progress
done  output  1  one-cycle pulse, coincident with HI/LO update of MULT/DIV ops
div_by_zero  output  1  pulses with done when a DIV/DIVU had b==0
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset: hi=0, lo=0, busy=0, done=0, div_by_zero=0, FSM to IDLE. rst mid-operation aborts it with no HI/LO update and no done.
- FSM states: IDLE, CALC, FIX, IDLE.
  - IDLE: start=1 with a MULT/MULTU/DIV/DIVU op latches a, b, op and operand signs, then goes to CALC with busy=1 from the next cycle.
  - CALC: runs exactly WIDTH iterations (counter 0..WIDTH-1), one per cycle.
    - Multiply: shift-add on magnitudes.
    - Divide: restoring shift-subtract on magnitudes.
  - FIX: one cycle that applies sign correction.
  - After FIX: loads hi/lo, pulses done, drops busy, returns to IDLE.
- Latency: start sampled at edge 0. busy=1 for cycles 1..WIDTH+1. At edge WIDTH+2, hi/lo are written, done=1 and busy=0 (WIDTH=32 gives 34 cycles). A new start is accepted in that same done cycle.
- MTHI/MTLO: with start=1 in IDLE, hi (or lo) <= a at the next edge. busy and done are not asserted.
- start while busy=1 is ignored entirely, including MTHI/MTLO.
- Undefined op codes are ignored.
- Multiply:
  - {hi,lo} = full 2*WIDTH-bit product.
  - MULT is signed: the product is negated in FIX when sign(a)^sign(b).
  - MULTU is unsigned: FIX is a pass-through.
- Divide:
  - lo = quotient truncated toward zero; hi = remainder, whose sign follows the dividend.
  - Signed corner case: 0x80000000 / -1 gives lo=0x80000000, hi=0, with no flag.
- Divide by zero (b==0, DIV or DIVU): lo=all ones, hi=a (unmodified), div_by_zero=1 for the done cycle. Latency is the same as a normal divide.
- hi/lo hold their value between operations. While busy, they show the old values; consumers must stall on busy.
- No overflow flag: MIPS mult/div never trap.

Decomposition:
- Shared header MulDivop.vh holds the op encodings MD_MULT=3'd0, MD_MULTU=3'd1, MD_DIV=3'd2, MD_DIVU=3'd3, MD_MTHI=3'd4, MD_MTLO=3'd5, plus the FSM state encodings.
- One sub-module is natural: muldiv_iter. It contains the shared WIDTH-cycle unsigned shift datapath (accumulator, shift register, counter), selected add/sub by a mode bit.
- Sign handling, special cases and the HI/LO registers stay in muldiv_unit.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> done exactly 34 cycles after start; hi=0xFFFFFFFE, lo=0x00000001; busy high cycles 1..33.
- MULT a=-3 b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. MULT 0x80000000*0x80000000 -> hi=0x40000000, lo=0.
- DIV a=-7 b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/7 -> lo=14, hi=2. DIV 0x80000000/-1 -> lo=0x80000000, hi=0, div_by_zero=0.
- DIVU a=0x12345678 b=0 -> lo=0xFFFFFFFF, hi=0x12345678, div_by_zero=1 only in the done cycle.
- start DIVU at cycle 0; start MTHI a=0xAA at cycle 5 -> MTHI ignored, final hi=remainder. MTHI a=0xAA in IDLE -> hi=0xAA next cycle, done stays 0.
- rst asserted at cycle 10 of a MULT -> next cycle busy=0, hi=lo=0, no done pulse. A fresh MULTU 6*7 then gives lo=42, hi=0.
